// File: rtl/claw_pkg.sv
// rtl/claw_pkg.sv - shared types and constants for the claw actuator sequencer
package claw_pkg;

    // Sequencer phases; 3-bit encoding keeps the state register narrow.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_EXTEND  = 3'd2,
        ST_GRIP    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RETRACT = 3'd5,
        ST_FINISH  = 3'd6
    } claw_state_t;

    // Which operation the current sequence performs.
    typedef enum logic {
        OP_PICK = 1'b0,
        OP_DROP = 1'b1
    } claw_op_t;

    // Registered drive bundle produced by the sequencer every cycle.
    typedef struct packed {
        logic stop;
        logic extend_claws;
        logic grip_close;
        logic busy;
        logic done;
        logic fault;
    } claw_drive_t;

    // Main navigation FSM code for the box pickup state.
    localparam logic [2:0] MAIN_PICK_BOX = 3'b101;

    // Default dwell lengths in clock cycles.
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_EXTEND_CYCLES  = 16;
    localparam int DEF_GRIP_TIMEOUT   = 32;
    localparam int DEF_RETRACT_CYCLES = 16;
    localparam int DEF_CNT_W          = 8;

    // A phase of n cycles loads the down-counter with n-1.
    function automatic int dwell_load(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/claw_dwell_timer.sv
// rtl/claw_dwell_timer.sv - loadable down-counter timing each sequencer phase
module claw_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/claw_sequencer.sv
// rtl/claw_sequencer.sv - timed pick/drop sequencer for the claw actuator
module claw_sequencer
    import claw_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int EXTEND_CYCLES  = DEF_EXTEND_CYCLES,
    parameter int GRIP_TIMEOUT   = DEF_GRIP_TIMEOUT,
    parameter int RETRACT_CYCLES = DEF_RETRACT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic pick_req,
    input  logic drop_req,
    input  logic grip_sensed,
    output logic stop,
    output logic extend_claws,
    output logic grip_close,
    output logic busy,
    output logic done,
    output logic fault,
    output logic holding
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(dwell_load(SETTLE_CYCLES));
    localparam logic [CNT_W-1:0] EXTEND_LOAD  = CNT_W'(dwell_load(EXTEND_CYCLES));
    localparam logic [CNT_W-1:0] GRIP_LOAD    = CNT_W'(dwell_load(GRIP_TIMEOUT));
    localparam logic [CNT_W-1:0] RETRACT_LOAD = CNT_W'(dwell_load(RETRACT_CYCLES));

    claw_state_t      state;
    claw_state_t      state_next;
    claw_op_t         op;
    claw_op_t         op_next;
    logic             fault_flag;
    logic             fault_flag_next;
    logic             holding_next;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;
    claw_drive_t      drive_next;

    claw_dwell_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .load_value(timer_value),
        .zero      (timer_zero)
    );

    // State, operation, fault flag and every output are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            op           <= OP_PICK;
            fault_flag   <= 1'b0;
            holding      <= 1'b0;
            stop         <= 1'b0;
            extend_claws <= 1'b0;
            grip_close   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_next;
            op           <= op_next;
            fault_flag   <= fault_flag_next;
            holding      <= holding_next;
            stop         <= drive_next.stop;
            extend_claws <= drive_next.extend_claws;
            grip_close   <= drive_next.grip_close;
            busy         <= drive_next.busy;
            done         <= drive_next.done;
            fault        <= drive_next.fault;
        end
    end

    // Next-state logic: a phase exits once its dwell counter reaches zero.
    always_comb begin
        state_next      = state;
        op_next         = op;
        fault_flag_next = fault_flag;
        holding_next    = holding;
        case (state)
            ST_IDLE: begin
                // An invalid request for the current holding state is dropped.
                if (pick_req && !holding) begin
                    state_next = ST_SETTLE;
                    op_next    = OP_PICK;
                end else if (drop_req && holding) begin
                    state_next = ST_SETTLE;
                    op_next    = OP_DROP;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_next = ST_EXTEND;
                end
            end
            ST_EXTEND: begin
                if (timer_zero) begin
                    if (op == OP_PICK) begin
                        state_next = ST_GRIP;
                    end else begin
                        state_next   = ST_RELEASE;
                        holding_next = 1'b0;
                    end
                end
            end
            ST_GRIP: begin
                // The sensor wins over the timeout if both land on the last cycle.
                if (grip_sensed) begin
                    state_next   = ST_RETRACT;
                    holding_next = 1'b1;
                end else if (timer_zero) begin
                    state_next      = ST_RETRACT;
                    fault_flag_next = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (timer_zero) begin
                    state_next = ST_RETRACT;
                end
            end
            ST_RETRACT: begin
                if (timer_zero) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next      = ST_IDLE;
                fault_flag_next = 1'b0;
            end
            default: begin
                state_next      = ST_IDLE;
                fault_flag_next = 1'b0;
            end
        endcase
    end

    // Reload the dwell timer whenever a new phase is entered.
    always_comb begin
        timer_load  = (state_next != state);
        timer_value = '0;
        case (state_next)
            ST_SETTLE:  timer_value = SETTLE_LOAD;
            ST_EXTEND:  timer_value = EXTEND_LOAD;
            ST_GRIP:    timer_value = GRIP_LOAD;
            ST_RELEASE: timer_value = EXTEND_LOAD;
            ST_RETRACT: timer_value = RETRACT_LOAD;
            default:    timer_value = '0;
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with it.
    always_comb begin
        drive_next              = '0;
        drive_next.grip_close   = holding_next;
        drive_next.busy         = (state_next != ST_IDLE);
        drive_next.stop         = (state_next != ST_IDLE);
        case (state_next)
            ST_EXTEND: begin
                drive_next.extend_claws = 1'b1;
            end
            ST_GRIP: begin
                drive_next.extend_claws = 1'b1;
                drive_next.grip_close   = 1'b1;
            end
            ST_RELEASE: begin
                drive_next.extend_claws = 1'b1;
                drive_next.grip_close   = 1'b0;
            end
            ST_FINISH: begin
                drive_next.done  = !fault_flag_next;
                drive_next.fault = fault_flag_next;
            end
            default: begin
                drive_next.extend_claws = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_claw_sequencer.sv
// tb/tb_claw_sequencer.sv - scoreboard bench for claw_sequencer
module tb_claw_sequencer;

    localparam int D_S = 4;
    localparam int D_E = 16;
    localparam int D_T = 32;
    localparam int D_R = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, pick, drop, grip, sel;

    logic d_pick, d_drop, d_grip;
    logic d_stop, d_ext, d_grip_close, d_busy, d_done, d_fault, d_hold;
    logic s_pick, s_drop, s_grip;
    logic s_stop, s_ext, s_grip_close, s_busy, s_done, s_fault, s_hold;

    assign d_pick = pick & ~sel;
    assign d_drop = drop & ~sel;
    assign d_grip = grip & ~sel;
    assign s_pick = pick & sel;
    assign s_drop = drop & sel;
    assign s_grip = grip & sel;

    claw_sequencer #(
        .SETTLE_CYCLES (D_S),
        .EXTEND_CYCLES (D_E),
        .GRIP_TIMEOUT  (D_T),
        .RETRACT_CYCLES(D_R),
        .CNT_W         (8)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .pick_req    (d_pick),
        .drop_req    (d_drop),
        .grip_sensed (d_grip),
        .stop        (d_stop),
        .extend_claws(d_ext),
        .grip_close  (d_grip_close),
        .busy        (d_busy),
        .done        (d_done),
        .fault       (d_fault),
        .holding     (d_hold)
    );

    claw_sequencer #(
        .SETTLE_CYCLES (1),
        .EXTEND_CYCLES (1),
        .GRIP_TIMEOUT  (1),
        .RETRACT_CYCLES(1),
        .CNT_W         (8)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .pick_req    (s_pick),
        .drop_req    (s_drop),
        .grip_sensed (s_grip),
        .stop        (s_stop),
        .extend_claws(s_ext),
        .grip_close  (s_grip_close),
        .busy        (s_busy),
        .done        (s_done),
        .fault       (s_fault),
        .holding     (s_hold)
    );

    logic o_stop, o_ext, o_grip_close, o_busy, o_done, o_fault, o_hold;
    assign o_stop       = sel ? s_stop       : d_stop;
    assign o_ext        = sel ? s_ext        : d_ext;
    assign o_grip_close = sel ? s_grip_close : d_grip_close;
    assign o_busy       = sel ? s_busy       : d_busy;
    assign o_done       = sel ? s_done       : d_done;
    assign o_fault      = sel ? s_fault      : d_fault;
    assign o_hold       = sel ? s_hold       : d_hold;

    typedef struct {
        int busy_len;
        int stop_len;
        int stop_out;
        int ext_len;
        int grip_len;
        int rel_idx;
        int done_cnt;
        int fault_cnt;
        int both_cnt;
        int holding_end;
    } seq_res_t;

    seq_res_t exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int all_outputs();
        return int'({o_stop, o_ext, o_grip_close, o_busy, o_done, o_fault, o_hold});
    endfunction

    // grip_at: -1 never sensed, -2 held high from before the request,
    // otherwise the GRIP cycle index on which grip_sensed is first seen.
    task automatic run_seq(input string name, input bit do_pick, input bit do_drop,
                           input bit exp_pick, input int grip_at);
        int s, e, t, r, g;
        bit ok, ended;
        seq_res_t ex, ob;
        s = sel ? 1 : D_S;
        e = sel ? 1 : D_E;
        t = sel ? 1 : D_T;
        r = sel ? 1 : D_R;
        if (exp_pick) begin
            g  = (grip_at == -1) ? t : ((grip_at < 0) ? 1 : grip_at + 1);
            ok = (grip_at != -1);
            ex.busy_len    = s + e + g + r + 1;
            ex.ext_len     = e + g;
            ex.grip_len    = ok ? g + r + 1 : t;
            ex.rel_idx     = s;
            ex.done_cnt    = ok ? 1 : 0;
            ex.fault_cnt   = ok ? 0 : 1;
            ex.holding_end = ok ? 1 : 0;
        end else begin
            ex.busy_len    = s + e + e + r + 1;
            ex.ext_len     = 2 * e;
            ex.grip_len    = s + e;
            ex.rel_idx     = s + e;
            ex.done_cnt    = 1;
            ex.fault_cnt   = 0;
            ex.holding_end = 0;
        end
        ex.stop_len = ex.busy_len;
        ex.stop_out = 0;
        ex.both_cnt = 0;
        exp_q.push_back(ex);

        if (grip_at == -2) grip = 1'b1;
        @(negedge clk);
        pick = do_pick;
        drop = do_drop;
        @(negedge clk);
        pick = 1'b0;
        drop = 1'b0;

        ob = '{default: 0};
        ob.rel_idx = -1;
        ended = 1'b0;
        for (int c = 0; c < 400 && !ended; c++) begin
            if (o_done)            ob.done_cnt++;
            if (o_fault)           ob.fault_cnt++;
            if (o_done && o_fault) ob.both_cnt++;
            if (o_busy) begin
                ob.busy_len++;
                if (o_stop)       ob.stop_len++;
                if (o_ext)        ob.ext_len++;
                if (o_grip_close) ob.grip_len++;
                if (ob.rel_idx < 0 && o_ext && !o_grip_close) ob.rel_idx = c;
                if (grip_at >= 0 && c == s + e + grip_at) grip = 1'b1;
            end else begin
                if (o_stop) ob.stop_out++;
                ob.holding_end = int'(o_hold);
                ended = 1'b1;
            end
            if (!ended) @(negedge clk);
        end
        grip = 1'b0;
        check({name, "_ended"}, int'(ended), 1);

        ex = exp_q.pop_front();
        check({name, "_busy_len"},  ob.busy_len,    ex.busy_len);
        check({name, "_stop_len"},  ob.stop_len,    ex.stop_len);
        check({name, "_stop_idle"}, ob.stop_out,    ex.stop_out);
        check({name, "_ext_len"},   ob.ext_len,     ex.ext_len);
        check({name, "_grip_len"},  ob.grip_len,    ex.grip_len);
        check({name, "_rel_idx"},   ob.rel_idx,     ex.rel_idx);
        check({name, "_done"},      ob.done_cnt,    ex.done_cnt);
        check({name, "_fault"},     ob.fault_cnt,   ex.fault_cnt);
        check({name, "_both"},      ob.both_cnt,    ex.both_cnt);
        check({name, "_holding"},   ob.holding_end, ex.holding_end);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        pick  = 1'b0;
        drop  = 1'b0;
        grip  = 1'b0;
        sel   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_held_outputs", all_outputs(), 0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_idle_outputs", all_outputs(), 0);

        // Pick with the jaws closing on the sixth GRIP cycle.
        run_seq("pick_grip5", 1'b1, 1'b0, 1'b1, 5);

        // Pick request while already holding is ignored.
        seen = 0;
        pick = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_busy || o_done || o_fault) seen++;
        end
        pick = 1'b0;
        @(negedge clk);
        if (o_busy) seen++;
        check("ignored_pick_activity", seen, 0);
        check("ignored_pick_holding", int'(o_hold), 1);

        // Drop the held box.
        run_seq("drop", 1'b0, 1'b1, 1'b0, -1);

        // Pick with no grip feedback times out.
        run_seq("pick_timeout", 1'b1, 1'b0, 1'b1, -1);

        // Both requests with nothing held: pick wins.
        run_seq("both_pick", 1'b1, 1'b1, 1'b1, 0);
        // Both requests while holding: drop wins.
        run_seq("both_drop", 1'b1, 1'b1, 1'b0, -1);

        // Reset in the middle of EXTEND.
        @(negedge clk);
        pick = 1'b1;
        @(negedge clk);
        pick = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_extend_active", int'(o_ext), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", all_outputs(), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", all_outputs(), 0);
        run_seq("pick_after_reset", 1'b1, 1'b0, 1'b1, 2);

        // Minimal dwell instance with grip_sensed held high throughout.
        sel = 1'b1;
        @(negedge clk);
        check("small_idle_outputs", all_outputs(), 0);
        run_seq("small_pick", 1'b1, 1'b0, 1'b1, -2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
